// File: rtl/core_regfile_mp.sv
// Multi-port core register file: GPRs + SP/LR/PC, status fields,
// two write ports (A: ALU, B: load writeback), same-cycle bypass and
// a load scoreboard for RAW hazard detection at decode.

// One combinational read port: bypass select, PC read offset, busy lookup.
module core_regfile_rdport #(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 16,
  parameter int AW        = 4,
  parameter int BYPASS    = 1,
  parameter int PC_RD_OFS = 4
) (
  input  logic [AW-1:0]                    addr,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]  regs,
  input  logic [NUM_REGS-1:0]              busy,
  input  logic                             wa_en,
  input  logic [AW-1:0]                    wa_addr,
  input  logic [DATA_W-1:0]                wa_data,
  input  logic                             wb_en,
  input  logic [AW-1:0]                    wb_addr,
  input  logic [DATA_W-1:0]                wb_data,
  output logic [DATA_W-1:0]                data,
  output logic                             busy_o
);
  localparam logic [AW-1:0] SP_A = AW'(NUM_REGS-3);
  localparam logic [AW-1:0] PC_A = AW'(NUM_REGS-1);

  logic in_rng, hit_a, hit_b;

  // Read mux: B bypass beats A bypass beats storage; PC never bypassed.
  always_comb begin
    in_rng = (int'(addr) < NUM_REGS);
    hit_b  = (BYPASS != 0) && wb_en && (wb_addr == addr);
    hit_a  = (BYPASS != 0) && wa_en && (wa_addr == addr);
    data   = '0;
    busy_o = 1'b0;
    if (in_rng) begin
      if (addr == PC_A) begin
        data = regs[addr] + DATA_W'(PC_RD_OFS);
      end else begin
        data = hit_b ? wb_data : (hit_a ? wa_data : regs[addr]);
        // stored SP is already aligned; this only matters for bypassed data
        if (addr == SP_A) data[1:0] = 2'b00;
      end
      // a writeback landing this cycle resolves the hazard early
      busy_o = busy[addr] & ~hit_b;
    end
  end
endmodule

module core_regfile_mp #(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 16,
  parameter int AW        = $clog2(NUM_REGS),
  parameter int NUM_RD    = 3,
  parameter int BYPASS    = 1,
  parameter int PC_STEP   = 4,
  parameter int PC_RD_OFS = 4,
  parameter int PC_RESET  = 0,
  parameter int SP_RESET  = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*AW-1:0]       rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       wa_en,
  input  logic [AW-1:0]              wa_addr,
  input  logic [DATA_W-1:0]          wa_data,
  input  logic                       wb_en,
  input  logic [AW-1:0]              wb_addr,
  input  logic [DATA_W-1:0]          wb_data,
  input  logic                       ld_issue,
  input  logic [AW-1:0]              ld_addr,
  input  logic                       pc_en,
  input  logic                       branch,
  input  logic                       link,
  input  logic [DATA_W-1:0]          br_target,
  input  logic [DATA_W-1:0]          br_link,
  input  logic                       apsr_we,
  input  logic [3:0]                 apsr_in,
  input  logic                       ipsr_we,
  input  logic [5:0]                 ipsr_in,
  input  logic                       pm_we,
  input  logic                       pm_in,
  output logic [DATA_W-1:0]          sp,
  output logic [DATA_W-1:0]          lr,
  output logic [DATA_W-1:0]          pc,
  output logic [3:0]                 apsr,
  output logic [5:0]                 ipsr,
  output logic                       primask
);
  localparam int SP_I = NUM_REGS-3;
  localparam int LR_I = NUM_REGS-2;
  localparam int PC_I = NUM_REGS-1;
  localparam logic [AW-1:0] SP_A = AW'(SP_I);
  localparam logic [AW-1:0] PC_A = AW'(PC_I);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]             busy_q, busy_d;
  logic [3:0]                      apsr_q, apsr_d;
  logic [5:0]                      ipsr_q, ipsr_d;
  logic                            pm_q, pm_d;
  logic                            wa_ok, wb_ok, ld_ok;

  // Next-state: A then B (B wins), PC/LR sequencing, scoreboard, status.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    apsr_d = apsr_we ? apsr_in : apsr_q;
    ipsr_d = ipsr_we ? ipsr_in : ipsr_q;
    pm_d   = pm_we   ? pm_in   : pm_q;
    // PC index is only reachable through pc_en
    wa_ok  = wa_en && (int'(wa_addr) < NUM_REGS) && (wa_addr != PC_A);
    wb_ok  = wb_en && (int'(wb_addr) < NUM_REGS) && (wb_addr != PC_A);
    ld_ok  = ld_issue && (int'(ld_addr) < NUM_REGS) && (ld_addr != PC_A);
    if (wa_ok)
      regs_d[wa_addr] = (wa_addr == SP_A) ? (wa_data & ~DATA_W'(3)) : wa_data;
    if (wb_ok)
      regs_d[wb_addr] = (wb_addr == SP_A) ? (wb_data & ~DATA_W'(3)) : wb_data;
    if (pc_en && branch) begin
      regs_d[PC_I] = br_target & ~DATA_W'(1);
      if (link) regs_d[LR_I] = br_link;
    end else if (pc_en) begin
      regs_d[PC_I] = regs_q[PC_I] + DATA_W'(PC_STEP);
    end
    // clear first so a same-cycle issue to the same register stays busy
    if (wb_en && (int'(wb_addr) < NUM_REGS)) busy_d[wb_addr] = 1'b0;
    if (ld_ok) busy_d[ld_addr] = 1'b1;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      regs_q       <= '0;
      regs_q[SP_I] <= DATA_W'(SP_RESET);
      regs_q[LR_I] <= '1;
      regs_q[PC_I] <= DATA_W'(PC_RESET);
      busy_q       <= '0;
      apsr_q       <= '0;
      ipsr_q       <= 6'h3f;
      pm_q         <= 1'b0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      apsr_q <= apsr_d;
      ipsr_q <= ipsr_d;
      pm_q   <= pm_d;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    core_regfile_rdport #(
      .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .AW(AW),
      .BYPASS(BYPASS), .PC_RD_OFS(PC_RD_OFS)
    ) u_rd (
      .addr   (rd_addr[i*AW +: AW]),
      .regs   (regs_q),
      .busy   (busy_q),
      .wa_en  (wa_en),
      .wa_addr(wa_addr),
      .wa_data(wa_data),
      .wb_en  (wb_en),
      .wb_addr(wb_addr),
      .wb_data(wb_data),
      .data   (rd_data[i*DATA_W +: DATA_W]),
      .busy_o (rd_busy[i])
    );
  end

  assign sp      = regs_q[SP_I];
  assign lr      = regs_q[LR_I];
  assign pc      = regs_q[PC_I];
  assign apsr    = apsr_q;
  assign ipsr    = ipsr_q;
  assign primask = pm_q;
endmodule

// File: tb/tb_core_regfile_mp.sv
// Bench for core_regfile_mp: directed scenarios plus a randomized run
// checked against an array-based reference model of the register file.
module tb_core_regfile_mp;
  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] rd_addr;
  logic [95:0] rd_data;
  logic [2:0]  rd_busy;
  logic        wa_en, wb_en, ld_issue, pc_en, branch, link;
  logic [3:0]  wa_addr, wb_addr, ld_addr;
  logic [31:0] wa_data, wb_data, br_target, br_link;
  logic        apsr_we, ipsr_we, pm_we, pm_in;
  logic [3:0]  apsr_in;
  logic [5:0]  ipsr_in;
  logic [31:0] sp, lr, pc;
  logic [3:0]  apsr;
  logic [5:0]  ipsr;
  logic        primask;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] m_regs[16];
  logic [31:0] m_pc;
  logic        m_busy[16];
  logic [3:0]  m_apsr;
  logic [5:0]  m_ipsr;
  logic        m_pm;

  core_regfile_mp dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ld_issue(ld_issue), .ld_addr(ld_addr), .pc_en(pc_en), .branch(branch), .link(link),
    .br_target(br_target), .br_link(br_link),
    .apsr_we(apsr_we), .apsr_in(apsr_in), .ipsr_we(ipsr_we), .ipsr_in(ipsr_in),
    .pm_we(pm_we), .pm_in(pm_in),
    .sp(sp), .lr(lr), .pc(pc), .apsr(apsr), .ipsr(ipsr), .primask(primask)
  );

  always #5 clk = ~clk;

  task automatic idle();
    rst = 1'b1; wa_en = 0; wb_en = 0; ld_issue = 0; pc_en = 0; branch = 0; link = 0;
    wa_addr = 0; wb_addr = 0; ld_addr = 0; wa_data = 0; wb_data = 0;
    br_target = 0; br_link = 0; apsr_we = 0; ipsr_we = 0; pm_we = 0;
    apsr_in = 0; ipsr_in = 0; pm_in = 0;
  endtask

  task automatic set_rd(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2);
    rd_addr = {a2, a1, a0};
  endtask

  // Model: what the architectural state becomes at the next edge.
  task automatic m_step();
    if (!rst) begin
      for (int i = 0; i < 16; i++) begin m_regs[i] = 0; m_busy[i] = 0; end
      m_regs[14] = 32'hFFFF_FFFF;
      m_pc = 0; m_apsr = 0; m_ipsr = 6'h3f; m_pm = 0;
    end else begin
      if (wa_en && wa_addr != 15) m_regs[wa_addr] = (wa_addr == 13) ? {wa_data[31:2], 2'b00} : wa_data;
      if (wb_en && wb_addr != 15) m_regs[wb_addr] = (wb_addr == 13) ? {wb_data[31:2], 2'b00} : wb_data;
      if (pc_en && branch) begin
        m_pc = {br_target[31:1], 1'b0};
        if (link) m_regs[14] = br_link;
      end else if (pc_en) m_pc = m_pc + 4;
      if (wb_en) m_busy[wb_addr] = 0;
      if (ld_issue && ld_addr != 15) m_busy[ld_addr] = 1;
      if (apsr_we) m_apsr = apsr_in;
      if (ipsr_we) m_ipsr = ipsr_in;
      if (pm_we) m_pm = pm_in;
    end
  endtask

  // Model of a combinational read with the current inputs applied.
  function automatic logic [31:0] m_read(input logic [3:0] a);
    logic [31:0] v;
    if (a == 15) return m_pc + 4;
    if (wb_en && wb_addr == a) v = wb_data;
    else if (wa_en && wa_addr == a) v = wa_data;
    else v = m_regs[a];
    if (a == 13) v[1:0] = 2'b00;
    return v;
  endfunction

  task automatic tick();
    m_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle(); rst = 1'b0; set_rd(4'd0, 4'd3, 4'd5);
    tick(); idle(); #1;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want %h", pc, 32'h0); end
    checks++; if (lr !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_lr got %h want %h", lr, 32'hFFFF_FFFF); end
    checks++; if (sp !== 32'h0) begin errors++; $display("FAIL reset_sp got %h want %h", sp, 32'h0); end
    checks++; if (ipsr !== 6'h3f) begin errors++; $display("FAIL reset_ipsr got %h want %h", ipsr, 6'h3f); end
    checks++; if ({apsr, primask} !== 5'h0) begin errors++; $display("FAIL reset_status got %h want 0", {apsr, primask}); end
    checks++; if (rd_busy !== 3'b000) begin errors++; $display("FAIL reset_busy got %b want 000", rd_busy); end
    checks++; if (rd_data !== 96'h0) begin errors++; $display("FAIL reset_reads got %h want 0", rd_data); end
  endtask

  task automatic test_dual_write();
    idle(); set_rd(4'd3, 4'd0, 4'd0);
    wa_en = 1; wa_addr = 3; wa_data = 32'h11; wb_en = 1; wb_addr = 3; wb_data = 32'h22; #1;
    checks++; if (rd_data[31:0] !== 32'h22) begin errors++; $display("FAIL dual_bypass got %h want %h", rd_data[31:0], 32'h22); end
    tick(); idle(); #1;
    checks++; if (rd_data[31:0] !== 32'h22) begin errors++; $display("FAIL dual_stored got %h want %h", rd_data[31:0], 32'h22); end
    // A-only bypass
    wa_en = 1; wa_addr = 3; wa_data = 32'h33; #1;
    checks++; if (rd_data[31:0] !== 32'h33) begin errors++; $display("FAIL a_bypass got %h want %h", rd_data[31:0], 32'h33); end
    tick(); idle();
  endtask

  task automatic test_pc();
    idle(); pc_en = 1;
    repeat (3) tick();
    checks++; if (pc !== 32'd12) begin errors++; $display("FAIL pc_step got %h want %h", pc, 32'd12); end
    branch = 1; link = 1; br_target = 32'h101; br_link = 32'h10;
    tick(); idle(); set_rd(4'd0, 4'd15, 4'd0); #1;
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL br_pc got %h want %h", pc, 32'h100); end
    checks++; if (lr !== 32'h10) begin errors++; $display("FAIL br_lr got %h want %h", lr, 32'h10); end
    checks++; if (rd_data[63:32] !== 32'h104) begin errors++; $display("FAIL pc_read got %h want %h", rd_data[63:32], 32'h104); end
    // LR written via A loses to branch-and-link in the same cycle
    wa_en = 1; wa_addr = 14; wa_data = 32'h5555; pc_en = 1; branch = 1; link = 1;
    br_target = 32'h200; br_link = 32'h77;
    tick(); idle(); #1;
    checks++; if (lr !== 32'h77) begin errors++; $display("FAIL lr_override got %h want %h", lr, 32'h77); end
  endtask

  task automatic test_scoreboard();
    idle(); set_rd(4'd0, 4'd0, 4'd5);
    ld_issue = 1; ld_addr = 5;
    tick(); idle(); #1;
    checks++; if (rd_busy[2] !== 1'b1) begin errors++; $display("FAIL sb_set got %b want 1", rd_busy[2]); end
    wb_en = 1; wb_addr = 5; wb_data = 32'hAB; #1;
    checks++; if (rd_busy[2] !== 1'b0) begin errors++; $display("FAIL sb_wb_busy got %b want 0", rd_busy[2]); end
    checks++; if (rd_data[95:64] !== 32'hAB) begin errors++; $display("FAIL sb_wb_data got %h want %h", rd_data[95:64], 32'hAB); end
    tick(); idle(); #1;
    checks++; if (rd_busy[2] !== 1'b0) begin errors++; $display("FAIL sb_cleared got %b want 0", rd_busy[2]); end
    ld_issue = 1; ld_addr = 5; wb_en = 1; wb_addr = 5; wb_data = 32'hCD;
    tick(); idle(); #1;
    checks++; if (rd_busy[2] !== 1'b1) begin errors++; $display("FAIL sb_set_wins got %b want 1", rd_busy[2]); end
    wb_en = 1; wb_addr = 5; wb_data = 32'hEF; tick(); idle();
  endtask

  task automatic test_sp_pc_write();
    logic [31:0] old_pc;
    idle();
    wa_en = 1; wa_addr = 13; wa_data = 32'h2000_0003;
    tick(); idle(); #1;
    checks++; if (sp !== 32'h2000_0000) begin errors++; $display("FAIL sp_align got %h want %h", sp, 32'h2000_0000); end
    old_pc = m_pc;
    wa_en = 1; wa_addr = 15; wa_data = 32'hDEAD_BEEF; wb_en = 1; wb_addr = 15; wb_data = 32'h1234;
    tick(); idle(); #1;
    checks++; if (pc !== old_pc) begin errors++; $display("FAIL pc_write_ignored got %h want %h", pc, old_pc); end
    ld_issue = 1; ld_addr = 15; tick(); idle(); set_rd(4'd15, 4'd0, 4'd0); #1;
    checks++; if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL pc_ld_ignored got %b want 0", rd_busy[0]); end
  endtask

  task automatic test_random();
    logic [3:0] a;
    logic       eb;
    for (int n = 0; n < 300; n++) begin
      idle();
      rd_addr   = 12'($urandom);
      wa_en     = 1'($urandom_range(0, 1)); wa_addr = 4'($urandom); wa_data = $urandom;
      wb_en     = 1'($urandom_range(0, 1)); wb_addr = 4'($urandom); wb_data = $urandom;
      if ($urandom_range(0, 3) == 0) wb_addr = wa_addr;
      ld_issue  = 1'($urandom_range(0, 1)); ld_addr = 4'($urandom);
      pc_en     = ($urandom_range(0, 2) == 0); branch = 1'($urandom); link = 1'($urandom);
      br_target = $urandom; br_link = $urandom;
      apsr_we   = 1'($urandom); apsr_in = 4'($urandom);
      ipsr_we   = 1'($urandom); ipsr_in = 6'($urandom);
      pm_we     = 1'($urandom); pm_in = 1'($urandom);
      #1;
      for (int p = 0; p < 3; p++) begin
        a  = rd_addr[p*4 +: 4];
        eb = m_busy[a] & ~(wb_en && wb_addr == a);
        checks++;
        if (rd_data[p*32 +: 32] !== m_read(a)) begin
          errors++; $display("FAIL rnd_read%0d r%0d got %h want %h", p, a, rd_data[p*32 +: 32], m_read(a));
        end
        checks++;
        if (rd_busy[p] !== eb) begin
          errors++; $display("FAIL rnd_busy%0d r%0d got %b want %b", p, a, rd_busy[p], eb);
        end
      end
      checks++;
      if ({sp, lr, pc} !== {m_regs[13], m_regs[14], m_pc}) begin
        errors++; $display("FAIL rnd_views got %h %h %h want %h %h %h", sp, lr, pc, m_regs[13], m_regs[14], m_pc);
      end
      checks++;
      if ({apsr, ipsr, primask} !== {m_apsr, m_ipsr, m_pm}) begin
        errors++; $display("FAIL rnd_status got %h want %h", {apsr, ipsr, primask}, {m_apsr, m_ipsr, m_pm});
      end
      tick();
    end
    idle();
  endtask

  task automatic test_reset_mid();
    idle(); ld_issue = 1; ld_addr = 7; apsr_we = 1; apsr_in = 4'hA;
    tick();
    idle(); rst = 0; pc_en = 1; wa_en = 1; wa_addr = 3; wa_data = 32'h99; ld_issue = 1; ld_addr = 2;
    tick(); idle(); set_rd(4'd7, 4'd3, 4'd2); #1;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rstmid_pc got %h want 0", pc); end
    checks++; if (lr !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rstmid_lr got %h want ffffffff", lr); end
    checks++; if (rd_busy !== 3'b000) begin errors++; $display("FAIL rstmid_busy got %b want 000", rd_busy); end
    checks++; if (rd_data[63:32] !== 32'h0) begin errors++; $display("FAIL rstmid_r3 got %h want 0", rd_data[63:32]); end
    checks++; if ({apsr, ipsr} !== {4'h0, 6'h3f}) begin errors++; $display("FAIL rstmid_status got %h want %h", {apsr, ipsr}, {4'h0, 6'h3f}); end
  endtask

  initial begin
    idle(); set_rd(4'd0, 4'd0, 4'd0);
    test_reset();
    test_dual_write();
    test_pc();
    test_scoreboard();
    test_sp_pc_write();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
